path_cmd_decoder: RTL and testbench

- Consumes the byte stream from uart_rx (rx_msg / rx_complete) and parses ASCII path-request frames of the form `$SS,EE#`.
- SS is the start node and EE the end node, each two decimal digits.
- On a valid frame it latches the start/end node numbers for the Dijkstra CPU driver (SP/EP) and issues a one-cycle start pulse (CPU_start).
- Sits between uart_rx and CPU_driver. It also reports framing/range/timeout errors and keeps saturating statistics counters.

---
 rtl/path_cmd_decoder.sv | 175 +++++++++++++++++
 tb/tb_path_cmd_decoder.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/path_cmd_decoder.sv
// Parses "$SS,EE#" path requests from the UART byte stream, latches start/end
// nodes for the CPU driver and issues a single start request per accepted frame.
module path_cmd_decoder #(
  parameter int NUM_NODES      = 30,
  parameter int TIMEOUT_CYCLES = 5000000,
  parameter int TO_W           = 23
) (
  input  logic       clk_50M,
  input  logic       reset,
  input  logic [7:0] rx_msg,
  input  logic       rx_complete,
  input  logic       cpu_busy,
  output logic [4:0] SP,
  output logic [4:0] EP,
  output logic       CPU_start,
  output logic       frame_err,
  output logic [1:0] err_code,
  output logic [7:0] ok_count,
  output logic [7:0] err_count
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SP_T = 3'd1,
    SP_U = 3'd2,
    SEP  = 3'd3,
    EP_T = 3'd4,
    EP_U = 3'd5,
    TERM = 3'd6
  } state_t;

  localparam logic [7:0] CH_DOLLAR = 8'h24;
  localparam logic [7:0] CH_COMMA  = 8'h2C;
  localparam logic [7:0] CH_HASH   = 8'h23;

  localparam logic [1:0] EC_CHAR  = 2'd1;
  localparam logic [1:0] EC_RANGE = 2'd2;
  localparam logic [1:0] EC_TOUT  = 2'd3;

  state_t          state_q, state_d;
  logic [3:0]      sp_t_q, sp_t_d, sp_u_q, sp_u_d;
  logic [3:0]      ep_t_q, ep_t_d, ep_u_q, ep_u_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic [4:0]      sp_q, sp_d, ep_q, ep_d;
  logic            pend_q, pend_d;
  logic            ferr_q, ferr_d;
  logic [1:0]      ecode_q, ecode_d;
  logic [7:0]      okc_q, okc_d, errc_q, errc_d;

  logic            is_digit;
  logic            to_hit;
  logic            frame_done;
  logic            frame_ok;
  logic            err_ev;
  logic [1:0]      err_cause;
  logic [6:0]      sp_val, ep_val;
  logic            in_range;
  logic            start_now;

  function automatic logic [6:0] node_val(input logic [3:0] tens, input logic [3:0] units);
    return (7'(tens) * 7'd10) + 7'(units);
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  assign is_digit = (rx_msg >= 8'h30) && (rx_msg <= 8'h39);
  assign to_hit   = (state_q != IDLE) && (to_cnt_q == TO_W'(TIMEOUT_CYCLES - 1));
  assign sp_val   = node_val(sp_t_q, sp_u_q);
  assign ep_val   = node_val(ep_t_q, ep_u_q);
  assign in_range = (sp_val < 7'(NUM_NODES)) && (ep_val < 7'(NUM_NODES));
  assign frame_ok = frame_done && in_range;
  // The request is combinational so it fires in the very cycle busy is low.
  assign start_now = pend_q && !cpu_busy;

  always_comb begin
    state_d    = state_q;
    sp_t_d     = sp_t_q;
    sp_u_d     = sp_u_q;
    ep_t_d     = ep_t_q;
    ep_u_d     = ep_u_q;
    frame_done = 1'b0;
    err_ev     = 1'b0;
    err_cause  = EC_CHAR;
    if (rx_complete) begin
      if ((state_q != IDLE) && (rx_msg == CH_DOLLAR)) begin
        // Resync: a fresh '$' mid-frame restarts parsing but is still an error.
        err_ev  = 1'b1;
        state_d = SP_T;
      end else begin
        case (state_q)
          IDLE: if (rx_msg == CH_DOLLAR) state_d = SP_T;
          SP_T: if (is_digit) begin sp_t_d = rx_msg[3:0]; state_d = SP_U; end
                else begin err_ev = 1'b1; state_d = IDLE; end
          SP_U: if (is_digit) begin sp_u_d = rx_msg[3:0]; state_d = SEP; end
                else begin err_ev = 1'b1; state_d = IDLE; end
          SEP:  if (rx_msg == CH_COMMA) state_d = EP_T;
                else begin err_ev = 1'b1; state_d = IDLE; end
          EP_T: if (is_digit) begin ep_t_d = rx_msg[3:0]; state_d = EP_U; end
                else begin err_ev = 1'b1; state_d = IDLE; end
          EP_U: if (is_digit) begin ep_u_d = rx_msg[3:0]; state_d = TERM; end
                else begin err_ev = 1'b1; state_d = IDLE; end
          TERM: begin
            state_d = IDLE;
            if (rx_msg == CH_HASH) frame_done = 1'b1;
            else err_ev = 1'b1;
          end
          default: state_d = IDLE;
        endcase
        if (frame_done && !in_range) begin
          err_ev    = 1'b1;
          err_cause = EC_RANGE;
        end
      end
    end else if (to_hit) begin
      err_ev    = 1'b1;
      err_cause = EC_TOUT;
      state_d   = IDLE;
    end
  end

  always_comb begin
    to_cnt_d = (state_q == IDLE || rx_complete || to_hit) ? '0 : to_cnt_q + 1'b1;
    sp_d     = frame_ok ? sp_val[4:0] : sp_q;
    ep_d     = frame_ok ? ep_val[4:0] : ep_q;
    // A frame landing while a request issues re-arms it for the new nodes.
    pend_d   = frame_ok ? 1'b1 : (start_now ? 1'b0 : pend_q);
    ferr_d   = err_ev;
    ecode_d  = err_ev ? err_cause : ecode_q;
    okc_d    = frame_ok ? sat_inc(okc_q) : okc_q;
    errc_d   = err_ev ? sat_inc(errc_q) : errc_q;
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      sp_t_q   <= '0;
      sp_u_q   <= '0;
      ep_t_q   <= '0;
      ep_u_q   <= '0;
      to_cnt_q <= '0;
      sp_q     <= '0;
      ep_q     <= '0;
      pend_q   <= 1'b0;
      ferr_q   <= 1'b0;
      ecode_q  <= '0;
      okc_q    <= '0;
      errc_q   <= '0;
    end else begin
      state_q  <= state_d;
      sp_t_q   <= sp_t_d;
      sp_u_q   <= sp_u_d;
      ep_t_q   <= ep_t_d;
      ep_u_q   <= ep_u_d;
      to_cnt_q <= to_cnt_d;
      sp_q     <= sp_d;
      ep_q     <= ep_d;
      pend_q   <= pend_d;
      ferr_q   <= ferr_d;
      ecode_q  <= ecode_d;
      okc_q    <= okc_d;
      errc_q   <= errc_d;
    end
  end

  assign SP        = sp_q;
  assign EP        = ep_q;
  assign CPU_start = start_now;
  assign frame_err = ferr_q;
  assign err_code  = ecode_q;
  assign ok_count  = okc_q;
  assign err_count = errc_q;

endmodule

// File: tb/tb_path_cmd_decoder.sv
// Directed bench for path_cmd_decoder with a shortened inter-byte timeout.
module tb_path_cmd_decoder;

  logic       clk_50M = 1'b0;
  logic       reset;
  logic [7:0] rx_msg;
  logic       rx_complete;
  logic       cpu_busy;
  logic [4:0] SP, EP;
  logic       CPU_start, frame_err;
  logic [1:0] err_code;
  logic [7:0] ok_count, err_count;

  int errors = 0;
  int checks = 0;
  int npulse = 0;

  path_cmd_decoder #(.NUM_NODES(30), .TIMEOUT_CYCLES(100), .TO_W(23)) dut (
    .clk_50M(clk_50M), .reset(reset), .rx_msg(rx_msg), .rx_complete(rx_complete),
    .cpu_busy(cpu_busy), .SP(SP), .EP(EP), .CPU_start(CPU_start),
    .frame_err(frame_err), .err_code(err_code), .ok_count(ok_count),
    .err_count(err_count)
  );

  always #10 clk_50M = ~clk_50M;

  always @(posedge clk_50M) if (CPU_start === 1'b1) npulse <= npulse + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge, after the byte was sampled.
  task automatic send_byte(input logic [7:0] b);
    rx_msg = b;
    rx_complete = 1'b1;
    @(negedge clk_50M);
    rx_complete = 1'b0;
    rx_msg = 8'h00;
  endtask

  task automatic send_str(input string s);
    for (int i = 0; i < s.len(); i++) send_byte(s[i]);
  endtask

  initial begin
    reset = 1'b1; rx_msg = 8'h00; rx_complete = 1'b0; cpu_busy = 1'b0;
    repeat (3) @(negedge clk_50M);
    check("rst_SP", SP, 0);
    check("rst_EP", EP, 0);
    check("rst_start", CPU_start, 0);
    check("rst_ferr", frame_err, 0);
    check("rst_code", err_code, 0);
    check("rst_ok", ok_count, 0);
    check("rst_err", err_count, 0);
    reset = 1'b0;
    @(negedge clk_50M);

    send_str("$04,17#");
    check("t1_SP", SP, 4);
    check("t1_EP", EP, 17);
    check("t1_start", CPU_start, 1);
    check("t1_ok", ok_count, 1);
    @(negedge clk_50M);
    check("t1_start_off", CPU_start, 0);
    check("t1_pulses", npulse, 1);

    cpu_busy = 1'b1;
    send_str("$03,09#");
    check("t2_SP_a", SP, 3);
    check("t2_EP_a", EP, 9);
    check("t2_start_busy", CPU_start, 0);
    repeat (100) @(negedge clk_50M);
    check("t2_start_wait", CPU_start, 0);
    send_str("$05,06#");
    check("t2_SP_b", SP, 5);
    check("t2_EP_b", EP, 6);
    check("t2_ok", ok_count, 3);
    check("t2_pulses_held", npulse, 1);
    cpu_busy = 1'b0;
    #1;
    check("t2_start_fall", CPU_start, 1);
    @(negedge clk_50M);
    check("t2_start_off", CPU_start, 0);
    repeat (3) @(negedge clk_50M);
    check("t2_pulses", npulse, 2);

    send_str("$31,02#");
    check("t3_ferr", frame_err, 1);
    check("t3_code", err_code, 2);
    check("t3_SP", SP, 5);
    check("t3_EP", EP, 6);
    check("t3_start", CPU_start, 0);
    @(negedge clk_50M);
    check("t3_ferr_off", frame_err, 0);
    send_str("$1x");
    check("t3b_ferr", frame_err, 1);
    check("t3b_code", err_code, 1);
    check("t3b_err", err_count, 2);
    send_str("0#");
    check("t3b_idle", frame_err, 0);
    check("t3b_err_hold", err_count, 2);
    check("t3_pulses", npulse, 2);

    send_str("$1$");
    check("t4_ferr", frame_err, 1);
    check("t4_code", err_code, 1);
    check("t4_err", err_count, 3);
    send_str("02,03#");
    check("t4_SP", SP, 2);
    check("t4_EP", EP, 3);
    check("t4_ok", ok_count, 4);
    check("t4_start", CPU_start, 1);
    @(negedge clk_50M);

    send_str("$12");
    repeat (99) @(negedge clk_50M);
    check("t5_ferr_early", frame_err, 0);
    @(negedge clk_50M);
    check("t5_ferr", frame_err, 1);
    check("t5_code", err_code, 3);
    check("t5_err", err_count, 4);
    @(negedge clk_50M);
    send_str("$01,02#");
    check("t5_SP", SP, 1);
    check("t5_EP", EP, 2);
    check("t5_ok", ok_count, 5);
    @(negedge clk_50M);

    send_str("$29,00#");
    check("b_SP29", SP, 29);
    check("b_EP0", EP, 0);
    @(negedge clk_50M);
    send_str("$00,30#");
    check("b_code30", err_code, 2);
    check("b_SP_keep", SP, 29);
    check("b_err", err_count, 5);

    send_str("$1");
    repeat (99) @(negedge clk_50M);
    send_byte("2");
    check("sim_ferr", frame_err, 0);
    send_str(",03#");
    check("sim_SP", SP, 12);
    check("sim_EP", EP, 3);
    check("sim_ok", ok_count, 7);
    check("sim_err", err_count, 5);
    repeat (2) @(negedge clk_50M);
    check("sim_pulses", npulse, 6);

    for (int i = 0; i < 256; i++) send_str("$x");
    check("sat_err", err_count, 255);
    check("sat_code", err_code, 1);
    check("sat_ok", ok_count, 7);

    send_str("$04,1");
    reset = 1'b1;
    #1;
    check("mr_SP", SP, 0);
    check("mr_EP", EP, 0);
    check("mr_ok", ok_count, 0);
    check("mr_err", err_count, 0);
    check("mr_code", err_code, 0);
    check("mr_ferr", frame_err, 0);
    check("mr_start", CPU_start, 0);
    @(negedge clk_50M);
    reset = 1'b0;
    send_str("7#");
    repeat (3) @(negedge clk_50M);
    check("mr_ok_after", ok_count, 0);
    check("mr_SP_after", SP, 0);
    check("mr_pulses", npulse, 6);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
